// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: SRAM-backed target endpoint for memory_req_t/memory_rsp_t with strobed writes,
// incrementing read bursts, a fixed-latency response pipe and a credit-guarded response FIFO.
//
// Ports:
//   clk_i        single clock, all state on rising edge
//   rst_ni       asynchronous active-low reset (SRAM contents are not reset)
//   req_valid_i  request valid
//   req_ready_o  request accepted when valid && ready
//   req_i        memory_req_t, MSB first: addr[31:0], write, data[31:0], strb[3:0], id[3:0],
//                source_id[3:0], coherent, burst_len[7:0], burst_last (87 bits)
//   rsp_valid_o  response valid (FIFO head)
//   rsp_ready_i  response consumed when valid && ready
//   rsp_o        memory_rsp_t, MSB first: data[31:0], id[3:0], error, last (38 bits)
//
// Configuration macro: RISCV_MEM_RSP_ERR_CHECK_EN
//   defined   -> byte addresses >= DEPTH*4 suppress writes and return data=0, error=1
//   undefined -> upper address bits ignored (aliasing), error always 0
module riscv_mem_responder #(
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 2,
    parameter int RSP_FIFO_DEPTH = 4,
    localparam int REQ_W         = 87,
    localparam int RSP_W         = 38
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [REQ_W-1:0] req_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [RSP_W-1:0] rsp_o
);
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [3:0]  source_id;
        logic        coherent;
        logic [7:0]  burst_len;
        logic        burst_last;
    } memory_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic        error;
        logic        last;
    } memory_rsp_t;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(RSP_FIFO_DEPTH);
    localparam int CW = $clog2(RSP_FIFO_DEPTH + 1);

    memory_req_t        req;
    state_t             state, state_nxt;
    logic [31:0]        mem [DEPTH];
    logic [31:0]        burst_addr;
    logic [3:0]         burst_id;
    logic [7:0]         beats_left;
    logic [CW-1:0]      credit;
    logic               ready_en;
    logic               has_credit, accept, issue, wr_en, beat_oor, push, pop;
    logic [31:0]        beat_addr, rd_data;
    logic [IW-1:0]      beat_idx;
    memory_rsp_t        beat_rsp;
    logic [LATENCY-1:0] pipe_v;
    memory_rsp_t        pipe_d [LATENCY];
    memory_rsp_t        fifo [RSP_FIFO_DEPTH];
    logic [PW:0]        wr_ptr, rd_ptr;
    logic               unused;

    assign req         = memory_req_t'(req_i);
    assign unused      = ^{req.source_id, req.coherent, req.addr, beat_addr};
    assign has_credit  = credit != '0;
    // ready_en keeps the port low through reset and for the release edge itself
    assign req_ready_o = ready_en && state == IDLE && has_credit;
    assign accept      = req_valid_i && req_ready_o;
    assign beat_addr   = state == IDLE ? req.addr : burst_addr;
    assign beat_idx    = beat_addr[IW+1:2];
    assign rd_data     = mem[beat_idx];
    assign wr_en       = accept && req.write && !beat_oor;

`ifdef RISCV_MEM_RSP_ERR_CHECK_EN
    assign beat_oor = |beat_addr[31:IW+2];
`else
    assign beat_oor = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        beat_rsp  = '0;
        if (state == IDLE) begin
            issue         = accept;
            beat_rsp.id   = req.id;
            beat_rsp.last = req.write ? req.burst_last : req.burst_len == '0;
            beat_rsp.data = req.write ? '0 : rd_data;
            if (accept && !req.write && req.burst_len != '0)
                state_nxt = BURST;
        end else begin
            issue         = has_credit;
            beat_rsp.id   = burst_id;
            beat_rsp.last = beats_left == 8'd1;
            beat_rsp.data = rd_data;
            if (issue && beats_left == 8'd1)
                state_nxt = IDLE;
        end
        beat_rsp.error = beat_oor;
        if (beat_oor)
            beat_rsp.data = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            burst_addr <= '0;
            burst_id   <= '0;
            beats_left <= '0;
            credit     <= CW'(RSP_FIFO_DEPTH);
            ready_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            // credit tracks free FIFO slots not already claimed by beats in flight
            credit   <= credit - CW'(issue) + CW'(pop);
            if (issue) begin
                burst_addr <= beat_addr + 32'd4;
                beats_left <= state == IDLE ? req.burst_len : beats_left - 8'd1;
                if (state == IDLE)
                    burst_id <= req.id;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (req.strb[b])
                    mem[beat_idx][8*b +: 8] <= req.data[8*b +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pipe_v <= '0;
        else
            pipe_v <= LATENCY'({pipe_v, issue});
    end

    always_ff @(posedge clk_i) begin
        pipe_d[0] <= beat_rsp;
        for (int i = 1; i < LATENCY; i++)
            pipe_d[i] <= pipe_d[i-1];
    end

    assign push        = pipe_v[LATENCY-1];
    assign rsp_valid_o = wr_ptr != rd_ptr;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_o       = rsp_valid_o ? fifo[rd_ptr[PW-1:0]] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{PW{1'b0}}, push};
            rd_ptr <= rd_ptr + {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fifo[wr_ptr[PW-1:0]] <= pipe_d[LATENCY-1];
    end
endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_riscv_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int FD      = 4;

    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
    logic        req_ready, rsp_valid;
    logic [86:0] req = '0;
    logic [37:0] rsp, held = '0;
    logic        held_v = 1'b0;
    logic [37:0] exp_q [$];
    int          n_checks = 0, n_fail = 0;

    riscv_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .RSP_FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_i(req), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] r(input logic [31:0] d, input logic [3:0] id, input logic e, input logic l);
        return {d, id, e, l};
    endfunction

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (held_v)
                check("rsp_stable", rsp, held);
            if (rsp_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %h expected none", rsp);
                end else
                    check("rsp", rsp, exp_q.pop_front());
            end else begin
                held_v = 1'b1;
                held   = rsp;
            end
        end else
            held_v = 1'b0;
    end

    task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] id, input logic [7:0] blen, input logic blast);
        int n = 0;
        req       = {addr, wr, data, strb, id, 4'h9, 1'b1, blen, blast};
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready %b expected 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", rsp, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);

        exp_q.push_back(r(0, 1, 0, 1));
        send(32'h10, 1, 32'hDEADBEEF, 4'hF, 1, 0, 1);
        exp_q.push_back(r(0, 1, 0, 0));
        send(32'h10, 1, 32'h0000AA00, 4'h2, 1, 0, 0);
        repeat (6) @(posedge clk);
        #1;
        exp_q.push_back(r(32'hDEADAAEF, 5, 0, 1));
        send(32'h10, 0, 0, 0, 5, 0, 0);
        repeat (LATENCY - 1) @(posedge clk);
        #1;
        check("lat_early", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("lat_due", rsp_valid, 1);
        wait_drain();

        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(r(0, 0, 0, 1));
            send(32'(k * 4), 1, 32'(32'h11111111 * (k + 1)), 4'hF, 0, 0, 1);
        end
        for (int k = 5; k < 8; k++) begin
            exp_q.push_back(r(0, 0, 0, 1));
            send(32'(k * 4), 1, 32'hA0000000 | 32'(k), 4'hF, 0, 0, 1);
        end
        exp_q.push_back(r(0, 0, 0, 1));
        send(32'((DEPTH - 1) * 4), 1, 32'hCAFEF00D, 4'hF, 0, 0, 1);
        wait_drain();

        for (int k = 0; k < 4; k++)
            exp_q.push_back(r(32'(32'h11111111 * (k + 1)), 2, 0, k == 3));
        send(32'h0, 0, 0, 0, 2, 3, 0);
        wait_drain();

        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(r(32'(32'h11111111 * (k + 1)), 6, 0, 0));
        exp_q.push_back(r(32'hDEADAAEF, 6, 0, 0));
        for (int k = 5; k < 8; k++)
            exp_q.push_back(r(32'hA0000000 | 32'(k), 6, 0, k == 7));
        send(32'h0, 0, 0, 0, 6, 7, 0);
        repeat (10) @(posedge clk);
        #1;
        check("bp_req_ready", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head", rsp, r(32'h11111111, 6, 0, 0));
        rsp_ready = 1'b1;
        wait_drain();

        exp_q.push_back(r(32'hCAFEF00D, 3, 0, 0));
`ifdef RISCV_MEM_RSP_ERR_CHECK_EN
        exp_q.push_back(r(32'h0, 3, 1, 1));
`else
        exp_q.push_back(r(32'h11111111, 3, 0, 1));
`endif
        send(32'((DEPTH - 1) * 4), 0, 0, 0, 3, 1, 0);
        wait_drain();

        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(r(32'(32'h11111111 * (k + 1)), 4'(8 + k), 0, 1));
                    send(32'(k * 4), 0, 0, 0, 4'(8 + k), 0, 0);
                end
            end
            begin
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ~rsp_ready;
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain();

        rsp_ready = 1'b0;
        send(32'h0, 0, 0, 0, 4, 7, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_after", req_ready, 1);
        exp_q.push_back(r(32'hDEADAAEF, 7, 0, 1));
        send(32'h10, 0, 0, 0, 7, 0, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
